// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared size codes, channel state and lane helpers for the memory bus master
package mem_bus_pkg;

  localparam logic [1:0]  SZ_WORD     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_BYTE     = 2'b10;
  localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } chan_state_e;

  // The reserved code 11 behaves exactly like a byte access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_BYTE : sz;
  endfunction

  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] sz);
    return ((sz == SZ_WORD) && (addr[1:0] != 2'b00)) || ((sz == SZ_HALF) && addr[0]);
  endfunction

  function automatic logic [31:0] store_lane(input logic [31:0] wdata, input logic [1:0] sz);
    case (sz)
      SZ_WORD: return wdata;
      SZ_HALF: return {16'h0000, wdata[15:0]};
      default: return {24'h000000, wdata[7:0]};
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] sz,
                                              input logic zero_ext);
    case (sz)
      SZ_WORD: return raw;
      SZ_HALF: return {{16{raw[15] & ~zero_ext}}, raw[15:0]};
      default: return {{24{raw[7] & ~zero_ext}}, raw[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - pipeline request channels and external instruction/data bus signals
interface mem_bus_master_if;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ready;
  logic        f_valid;
  logic [31:0] f_inst;
  logic        f_err;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] IAD;
  logic [31:0] IDT;
  logic        ACKI_n;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport master (
    input  f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
           IDT, ACKI_n, ACKD_n,
    output f_ready, f_valid, f_inst, f_err, d_ready, d_done, d_rdata, d_err,
           IAD, DAD, MREQ, WRITE, SIZE
  );

  modport slave (
    output f_req, f_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
           IDT, ACKI_n, ACKD_n,
    input  f_ready, f_valid, f_inst, f_err, d_ready, d_done, d_rdata, d_err,
           IAD, DAD, MREQ, WRITE, SIZE
  );

endinterface

// File: rtl/bus_chan_ctrl.sv
// rtl/bus_chan_ctrl.sv - IDLE/BUSY handshake FSM with acknowledge timeout for one bus channel
module bus_chan_ctrl
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  input  logic reject,
  input  logic ack_n,
  output logic ready,
  output logic finish,
  output logic ack_ok,
  output logic done,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) cnt_q <= '0;
      else                 cnt_q <= cnt_q + CW'(1);
      done <= finish | reject;
      err  <= timed_out | reject;
    end
  end

  // Being in BUSY already implies the launch edge is behind us, so a stale
  // acknowledge held low across IDLE is never honoured.
  always_comb begin
    state_d   = state_q;
    ack_ok    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: if (launch) state_d = BUSY;
      BUSY: begin
        if (!ack_n) begin
          ack_ok  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign finish = ack_ok | timed_out;
  assign ready  = (state_q == IDLE);

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - fetch and load/store initiator for the external instruction and data buses
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] IMEM_START = 32'h0000_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_master_if.master  bus,
  inout  wire  [31:0]       DDT
);

  logic        f_ready, f_launch, f_finish, f_ack_ok, f_done, f_err;
  logic        d_ready, d_accept, d_mis, d_launch, d_reject;
  logic        d_finish, d_ack_ok, d_done, d_err;
  logic [31:0] iad_q, inst_q;
  logic [31:0] dad_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        write_q, mreq_q, zext_q;

  assign f_launch = bus.f_req & f_ready;
  assign d_accept = bus.d_req & d_ready;
  assign d_mis    = misaligned(bus.d_addr, bus.d_size);
  assign d_launch = d_accept & ~d_mis;
  assign d_reject = d_accept & d_mis;

  bus_chan_ctrl #(.TIMEOUT(TIMEOUT)) u_fetch_chan (
    .clk    (clk),
    .rst    (rst),
    .launch (f_launch),
    .reject (1'b0),
    .ack_n  (bus.ACKI_n),
    .ready  (f_ready),
    .finish (f_finish),
    .ack_ok (f_ack_ok),
    .done   (f_done),
    .err    (f_err)
  );

  bus_chan_ctrl #(.TIMEOUT(TIMEOUT)) u_data_chan (
    .clk    (clk),
    .rst    (rst),
    .launch (d_launch),
    .reject (d_reject),
    .ack_n  (bus.ACKD_n),
    .ready  (d_ready),
    .finish (d_finish),
    .ack_ok (d_ack_ok),
    .done   (d_done),
    .err    (d_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iad_q  <= IMEM_START;
      inst_q <= '0;
    end else begin
      if (f_launch) iad_q <= bus.f_addr;
      if (f_ack_ok)      inst_q <= bus.IDT;
      else if (f_finish) inst_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dad_q   <= '0;
      size_q  <= SZ_WORD;
      write_q <= 1'b0;
      mreq_q  <= 1'b0;
      zext_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (d_launch) begin
        dad_q   <= bus.d_addr;
        size_q  <= norm_size(bus.d_size);
        write_q <= bus.d_we;
        mreq_q  <= 1'b1;
        zext_q  <= bus.d_unsigned;
        wdata_q <= store_lane(bus.d_wdata, norm_size(bus.d_size));
      end else if (d_finish) begin
        mreq_q  <= 1'b0;
        write_q <= 1'b0;
      end
      // A completed store leaves the previous load result in place.
      if (d_ack_ok) begin
        if (!write_q) rdata_q <= load_extend(DDT, size_q, zext_q);
      end else if (d_finish || d_reject) begin
        rdata_q <= '0;
      end
    end
  end

  assign DDT = (mreq_q & write_q) ? wdata_q : 32'bz;

  assign bus.f_ready = f_ready;
  assign bus.f_valid = f_done;
  assign bus.f_inst  = inst_q;
  assign bus.f_err   = f_err;
  assign bus.d_ready = d_ready;
  assign bus.d_done  = d_done;
  assign bus.d_rdata = rdata_q;
  assign bus.d_err   = d_err;
  assign bus.IAD     = iad_q;
  assign bus.DAD     = dad_q;
  assign bus.MREQ    = mreq_q;
  assign bus.WRITE   = write_q;
  assign bus.SIZE    = size_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master with behavioural responders
module tb_mem_bus_master;

  localparam int          TMO   = 4;
  localparam logic [31:0] ISTRT = 32'h0000_0000;
  localparam logic [31:0] HIZ   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  wire  [31:0] DDT;
  logic [31:0] tb_ddt = '0;
  logic        tb_ddt_en = 1'b0;

  // A released data bus is pulled up, so high-Z reads back as all ones.
  pullup (DDT);
  assign DDT = tb_ddt_en ? tb_ddt : 32'bz;

  mem_bus_master_if bus ();

  mem_bus_master #(.IMEM_START(ISTRT), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .DDT (DDT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          d_lat = 1, d_cnt = 0, i_lat = 1, i_cnt = 0;
  logic [31:0] d_resp = '0, i_resp = '0;
  logic        d_stale = 1'b0, i_stale = 1'b0, i_active = 1'b0;

  // Data responder: acknowledges on the d_lat-th cycle of MREQ (0 = never).
  always @(negedge clk) begin
    if (bus.MREQ === 1'b1) begin
      d_cnt = d_cnt + 1;
      if (d_lat != 0 && d_cnt == d_lat) begin
        bus.ACKD_n = 1'b0;
        tb_ddt     = d_resp;
        tb_ddt_en  = !bus.WRITE;
      end else begin
        bus.ACKD_n = 1'b1;
        tb_ddt_en  = 1'b0;
      end
    end else begin
      d_cnt      = 0;
      bus.ACKD_n = !d_stale;
      tb_ddt_en  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (i_active) begin
      i_cnt = i_cnt + 1;
      if (i_lat != 0 && i_cnt == i_lat) begin
        bus.ACKI_n = 1'b0;
        bus.IDT    = i_resp;
      end else begin
        bus.ACKI_n = 1'b1;
        bus.IDT    = ~i_resp;
      end
    end else begin
      i_cnt      = 0;
      bus.ACKI_n = !i_stale;
      bus.IDT    = ~i_resp;
    end
  end

  function automatic logic [31:0] m_load(input logic [31:0] r, input logic [1:0] sz, input logic uns);
    longint span, v;
    if (sz == 2'd0) return r;
    span = (sz == 2'd1) ? 65536 : 256;
    v = longint'(r) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_lane(input logic [31:0] wd, input logic [1:0] sz);
    longint w;
    w = longint'(wd);
    if (sz == 2'd1)      w = w % 65536;
    else if (sz != 2'd0) w = w % 256;
    return 32'(w);
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd0 && a % 4 != 0) || (sz == 2'd1 && a % 2 != 0);
  endfunction

  function automatic int m_cyc(input int lat);
    return (lat >= 1 && lat <= TMO) ? lat : TMO;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_data(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] resp,
                          input int lat, output int cyc, output logic err, output logic [31:0] rdata,
                          output int mreq_n, output logic [1:0] size_s, output logic write_s,
                          output logic [31:0] dad_s, output logic [31:0] ddt_s,
                          output logic [31:0] ddt_after, output logic rdy0, output logic pulse_ok);
    d_lat = lat; d_resp = resp;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
    bus.d_addr = addr; bus.d_wdata = wdata;
    tick();
    bus.d_req = 1'b0;
    size_s = bus.SIZE; write_s = bus.WRITE; dad_s = bus.DAD; ddt_s = DDT; rdy0 = bus.d_ready;
    mreq_n = 0; cyc = -1; err = 1'b0; rdata = '0; ddt_after = '0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (bus.MREQ) mreq_n++;
      if (bus.d_done) begin
        cyc = k; err = bus.d_err; rdata = bus.d_rdata; ddt_after = DDT;
        break;
      end
    end
    tick();
    pulse_ok = (bus.d_done === 1'b0) && (bus.d_ready === 1'b1);
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] resp, input int lat,
                           output int cyc, output logic err, output logic [31:0] inst,
                           output logic [31:0] iad_s, output logic rdy0, output logic pulse_ok);
    i_lat = lat; i_resp = resp;
    bus.f_req = 1'b1; bus.f_addr = addr;
    tick();
    bus.f_req = 1'b0; i_active = 1'b1;
    iad_s = bus.IAD; rdy0 = bus.f_ready;
    cyc = -1; err = 1'b0; inst = '0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (bus.f_valid) begin
        cyc = k; err = bus.f_err; inst = bus.f_inst;
        break;
      end
    end
    i_active = 1'b0;
    tick();
    pulse_ok = (bus.f_valid === 1'b0) && (bus.f_ready === 1'b1);
  endtask

  int          cyc, mq, fcyc;
  logic        err, wr_s, rdy0, pok, ferr, frdy0, fpok;
  logic [1:0]  sz_s;
  logic [31:0] rd, dad_s, ddt_s, ddt_a, finst, fiad;

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.MREQ !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got %b want 0", bus.MREQ); end
    n_checks++; if (bus.IAD !== ISTRT) begin n_fail++; $display("FAIL reset_iad got %h want %h", bus.IAD, ISTRT); end
    rst = 1'b1;
    tick();
    n_checks++; if ({bus.f_ready, bus.d_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b want 11", {bus.f_ready, bus.d_ready}); end
    n_checks++; if ({bus.WRITE, bus.SIZE} !== 3'b000) begin n_fail++; $display("FAIL reset_write_size got %b want 000", {bus.WRITE, bus.SIZE}); end
    n_checks++; if (bus.DAD !== 32'h0) begin n_fail++; $display("FAIL reset_dad got %h want 0", bus.DAD); end
    n_checks++; if (DDT !== HIZ) begin n_fail++; $display("FAIL reset_ddt got %h want released", DDT); end
    n_checks++; if ({bus.d_done, bus.f_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {bus.d_done, bus.f_valid}); end
    n_checks++; if ({bus.d_rdata, bus.f_inst} !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {bus.d_rdata, bus.f_inst}); end
  endtask

  task automatic test_word_load();
    run_data(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0, 32'h1122_3344, 1,
             cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL word_load_latency got %0d want 1", cyc); end
    n_checks++; if (mq !== 1) begin n_fail++; $display("FAIL word_load_mreq_cycles got %0d want 1", mq); end
    n_checks++; if ({sz_s, wr_s, dad_s} !== {2'b00, 1'b0, 32'h0800_0010}) begin n_fail++; $display("FAIL word_load_bus got %b/%b/%h want 00/0/08000010", sz_s, wr_s, dad_s); end
    n_checks++; if ({err, rd} !== {1'b0, 32'h1122_3344}) begin n_fail++; $display("FAIL word_load_data got %b/%h want 0/11223344", err, rd); end
    n_checks++; if ({rdy0, pok} !== 2'b01) begin n_fail++; $display("FAIL word_load_ready_pulse got %b want 01", {rdy0, pok}); end
  endtask

  task automatic test_byte_load();
    run_data(1'b0, 2'b10, 1'b0, 32'h0800_0023, 32'h0, 32'h5A5A_5A80, 1,
             cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
    n_checks++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_load_signed got %h want ffffff80", rd); end
    run_data(1'b0, 2'b10, 1'b1, 32'h0800_0023, 32'h0, 32'h5A5A_5A80, 1,
             cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
    n_checks++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_load_unsigned got %h want 00000080", rd); end
  endtask

  task automatic test_half_store();
    run_data(1'b1, 2'b01, 1'b0, 32'h0800_0002, 32'hDEAD_BEEF, 32'h0, 1,
             cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
    n_checks++; if ({sz_s, wr_s} !== 3'b011) begin n_fail++; $display("FAIL half_store_size_write got %b want 011", {sz_s, wr_s}); end
    n_checks++; if (ddt_s !== 32'h0000_BEEF) begin n_fail++; $display("FAIL half_store_lane got %h want 0000beef", ddt_s); end
    n_checks++; if (ddt_a !== HIZ) begin n_fail++; $display("FAIL half_store_release got %h want released", ddt_a); end
    n_checks++; if ({cyc, err} !== {32'sd1, 1'b0}) begin n_fail++; $display("FAIL half_store_done got %0d/%b want 1/0", cyc, err); end
  endtask

  task automatic test_misaligned();
    run_data(1'b0, 2'b00, 1'b0, 32'h0800_0001, 32'h0, 32'h1234_5678, 1,
             cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
    n_checks++; if (mq !== 0) begin n_fail++; $display("FAIL misaligned_mreq got %0d want 0", mq); end
    n_checks++; if ({cyc, err, rd} !== {32'sd0, 1'b1, 32'h0}) begin n_fail++; $display("FAIL misaligned_done got %0d/%b/%h want 0/1/0", cyc, err, rd); end
    n_checks++; if ({rdy0, pok} !== 2'b11) begin n_fail++; $display("FAIL misaligned_ready got %b want 11", {rdy0, pok}); end
  endtask

  task automatic test_fetch();
    run_fetch(32'h0000_1230, 32'hCAFE_F00D, 3, fcyc, ferr, finst, fiad, frdy0, fpok);
    n_checks++; if ({fcyc, ferr} !== {32'sd3, 1'b0}) begin n_fail++; $display("FAIL fetch_latency got %0d/%b want 3/0", fcyc, ferr); end
    n_checks++; if ({finst, fiad} !== {32'hCAFE_F00D, 32'h0000_1230}) begin n_fail++; $display("FAIL fetch_data got %h/%h want cafef00d/00001230", finst, fiad); end
    n_checks++; if ({frdy0, fpok} !== 2'b01) begin n_fail++; $display("FAIL fetch_ready_pulse got %b want 01", {frdy0, fpok}); end
  endtask

  task automatic test_timeout();
    fork
      run_data(1'b0, 2'b00, 1'b0, 32'h0800_0040, 32'h0, 32'h7777_7777, 0,
               cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
      run_fetch(32'h0000_2000, 32'h9999_9999, 0, fcyc, ferr, finst, fiad, frdy0, fpok);
    join
    n_checks++; if ({cyc, err, rd} !== {TMO, 1'b1, 32'h0}) begin n_fail++; $display("FAIL data_timeout got %0d/%b/%h want %0d/1/0", cyc, err, rd, TMO); end
    n_checks++; if (mq !== TMO) begin n_fail++; $display("FAIL data_timeout_mreq got %0d want %0d", mq, TMO); end
    n_checks++; if ({fcyc, ferr, finst} !== {TMO, 1'b1, 32'h0}) begin n_fail++; $display("FAIL fetch_timeout got %0d/%b/%h want %0d/1/0", fcyc, ferr, finst, TMO); end
  endtask

  task automatic test_stale_ack();
    int dn;
    dn = 0;
    d_stale = 1'b1; i_stale = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      dn += int'(bus.d_done) + int'(bus.f_valid);
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL stale_ack_idle got %0d pulses want 0", dn); end
    fork
      run_data(1'b0, 2'b01, 1'b1, 32'h0800_0006, 32'h0, 32'h0000_8001, 2,
               cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
      run_fetch(32'h0000_3000, 32'h0BAD_C0DE, 2, fcyc, ferr, finst, fiad, frdy0, fpok);
    join
    n_checks++; if ({cyc, rd} !== {32'sd2, 32'h0000_8001}) begin n_fail++; $display("FAIL stale_ack_data got %0d/%h want 2/00008001", cyc, rd); end
    n_checks++; if ({fcyc, finst} !== {32'sd2, 32'h0BAD_C0DE}) begin n_fail++; $display("FAIL stale_ack_fetch got %0d/%h want 2/0badc0de", fcyc, finst); end
    d_stale = 1'b0; i_stale = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int dn;
    dn = 0;
    d_lat = 1; d_resp = 32'h0102_0304;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_addr = 32'h0800_0100;
    for (int k = 0; k < 8; k++) begin
      tick();
      dn += int'(bus.d_done);
    end
    bus.d_req = 1'b0;
    repeat (2) tick();
    n_checks++; if (dn !== 4) begin n_fail++; $display("FAIL back_to_back got %0d completions want 4", dn); end
  endtask

  task automatic test_random();
    logic        we, uns, mis, tmo;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rsp, fa, fr;
    int          lat, flat, ec;
    for (int it = 0; it < 30; it++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      addr = $urandom; if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
      wd = $urandom; rsp = $urandom; lat = $urandom_range(0, 6);
      fa = $urandom & 32'hFFFF_FFFC; fr = $urandom; flat = $urandom_range(0, 6);
      mis = m_mis(addr, sz);
      tmo = !(lat >= 1 && lat <= TMO);
      ec  = mis ? 0 : m_cyc(lat);
      fork
        run_data(we, sz, uns, addr, wd, rsp, lat, cyc, err, rd, mq, sz_s, wr_s, dad_s, ddt_s, ddt_a, rdy0, pok);
        run_fetch(fa, fr, flat, fcyc, ferr, finst, fiad, frdy0, fpok);
      join
      n_checks++; if ({cyc, mq} !== {ec, mis ? 0 : ec}) begin n_fail++; $display("FAIL rand%0d_timing got %0d/%0d want %0d", it, cyc, mq, ec); end
      n_checks++; if (err !== (mis || tmo)) begin n_fail++; $display("FAIL rand%0d_err got %b want %b", it, err, mis || tmo); end
      if (!we || mis || tmo) begin
        n_checks++; if (rd !== ((mis || tmo) ? 32'h0 : m_load(rsp, sz, uns))) begin n_fail++; $display("FAIL rand%0d_rdata got %h want %h", it, rd, (mis || tmo) ? 32'h0 : m_load(rsp, sz, uns)); end
      end
      if (!mis) begin
        n_checks++; if ({dad_s, sz_s, wr_s} !== {addr, (sz == 2'b11) ? 2'b10 : sz, we}) begin n_fail++; $display("FAIL rand%0d_bus got %h/%b/%b want %h/%b/%b", it, dad_s, sz_s, wr_s, addr, sz, we); end
      end
      n_checks++; if (ddt_s !== ((we && !mis) ? m_lane(wd, sz) : HIZ)) begin n_fail++; $display("FAIL rand%0d_ddt got %h want %h", it, ddt_s, (we && !mis) ? m_lane(wd, sz) : HIZ); end
      if (we) begin
        n_checks++; if (ddt_a !== HIZ) begin n_fail++; $display("FAIL rand%0d_ddt_release got %h want released", it, ddt_a); end
      end
      n_checks++; if ({rdy0, pok} !== {mis, 1'b1}) begin n_fail++; $display("FAIL rand%0d_ready got %b want %b1", it, {rdy0, pok}, mis); end
      n_checks++; if ({fcyc, ferr, fiad} !== {m_cyc(flat), !(flat >= 1 && flat <= TMO), fa}) begin n_fail++; $display("FAIL rand%0d_fetch got %0d/%b/%h want %0d/%h", it, fcyc, ferr, fiad, m_cyc(flat), fa); end
      n_checks++; if (finst !== ((flat >= 1 && flat <= TMO) ? fr : 32'h0)) begin n_fail++; $display("FAIL rand%0d_inst got %h want %h", it, finst, (flat >= 1 && flat <= TMO) ? fr : 32'h0); end
    end
  endtask

  task automatic test_reset_mid_store();
    int dn;
    dn = 0;
    run_fetch(32'h0000_5554, 32'h1111_2222, 1, fcyc, ferr, finst, fiad, frdy0, fpok);
    d_lat = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_addr = 32'h0800_0200; bus.d_wdata = 32'h1357_9BDF;
    tick();
    bus.d_req = 1'b0;
    tick();
    n_checks++; if ({bus.MREQ, bus.WRITE} !== 2'b11) begin n_fail++; $display("FAIL mid_store_active got %b want 11", {bus.MREQ, bus.WRITE}); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({bus.MREQ, bus.WRITE} !== 2'b00) begin n_fail++; $display("FAIL mid_store_reset_strobes got %b want 00", {bus.MREQ, bus.WRITE}); end
    n_checks++; if (DDT !== HIZ) begin n_fail++; $display("FAIL mid_store_reset_ddt got %h want released", DDT); end
    n_checks++; if (bus.IAD !== ISTRT) begin n_fail++; $display("FAIL mid_store_reset_iad got %h want %h", bus.IAD, ISTRT); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      dn += int'(bus.d_done) + int'(bus.MREQ);
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL mid_store_after_release got %0d events want 0", dn); end
  endtask

  initial begin
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_fetch();
    test_timeout();
    test_stale_ack();
    test_back_to_back();
    test_random();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Processor-side initiator for the external instruction and data memory buses of `top`. It accepts fetch and load/store requests from the pipeline and drives the bus address and strobe lines, and the DDT data lane for stores. It waits for the responder's active-low acknowledge, then returns instruction words or sign/zero-extended load data with a one-cycle done pulse. A per-channel timeout turns a missing acknowledge into an error.

## Interface
- `IMEM_START`, 32'h0000_0000: IAD value after reset.
- `TIMEOUT`, 16: bus cycles without an acknowledge before the access is aborted (≥1).
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `f_req` in 1: fetch request; accepted at an edge where `f_ready`=1.
- `f_addr` in 32: fetch address (word-aligned).
- `f_ready` out 1: fetch channel idle.
- `f_valid` out 1: one-cycle pulse, `f_inst` valid.
- `f_inst` out 32: fetched instruction.
- `f_err` out 1: with `f_valid`, fetch timed out.
- `d_req` in 1: data request; accepted at an edge where `d_ready`=1.
- `d_we` in 1: 1 = store.
- `d_size` in 2: 00 word, 01 half, 10 byte; 11 is treated as byte.
- `d_unsigned` in 1: zero-extend load (else sign-extend).
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data, right-aligned.
- `d_ready` out 1: data channel idle.
- `d_done` out 1: one-cycle completion pulse.
- `d_rdata` out 32: extended load data, valid with `d_done` and `d_we`=0.
- `d_err` out 1: with `d_done`: misaligned or timeout.
- `IAD` out 32: instruction address bus.
- `IDT` in 32: instruction data bus.
- `ACKI_n` in 1: instruction acknowledge, active-low.
- `DAD` out 32: data address bus.
- `MREQ` out 1: data request strobe.
- `WRITE` out 1: 1 = store cycle.
- `SIZE` out 2: access size, same encoding as `d_size`.
- `DDT` inout 32: data bus.
- `ACKD_n` in 1: data acknowledge, active-low.

## Operation
- **Channel states (each channel):** IDLE and BUSY.
  - IDLE → BUSY on an accepted request.
  - BUSY → IDLE when the acknowledge is sampled low at a posedge, or when the timeout counter reaches `TIMEOUT`.
- **Data launch:**
  - On accept, register `DAD`=`d_addr`, `SIZE`, `WRITE`=`d_we`, and `MREQ`=1.
  - `MREQ` and `WRITE` drop at the same edge that leaves BUSY.
- **Misalignment:** word with addr[1:0]≠0, or half with addr[0]≠0.
  - No bus cycle is issued and `MREQ` stays 0.
  - The channel stays IDLE. `d_done`=`d_err`=1 at the next edge.
- **Store lane placement:** `DDT` is driven only while `MREQ`&`WRITE`, otherwise high-Z.
  - Word: all 32 bits.
  - Half: `d_wdata[15:0]` on DDT[15:0], upper bits 0.
  - Byte: `d_wdata[7:0]` on DDT[7:0], upper bits 0.
  - The responder performs the byte-lane addressing.
- **Load extraction:** at the acknowledge edge capture DDT.
  - Half: DDT[15:0], extended per `d_unsigned`.
  - Byte: DDT[7:0], extended per `d_unsigned`.
  - Word: DDT unchanged.
- **Fetch:**
  - On accept, register `IAD`=`f_addr`.
  - On `ACKI_n` low in BUSY, capture `IDT` into `f_inst` and pulse `f_valid`.
  - `IAD` holds its last value while IDLE.
- **Acknowledge qualification:** an acknowledge is honoured only in BUSY and only at edges after the launch edge. A low acknowledge while IDLE is ignored, because the responder may leave it low.
- **Timeout:** counts BUSY edges. At `TIMEOUT` the channel deasserts strobes, returns to IDLE, and pulses done/valid with err=1; rdata and inst are 0.
- **Concurrency:** the two channels are fully independent; simultaneous requests proceed in parallel.
- **Reset (asynchronous, including mid-access):** all state IDLE.
  - `MREQ`=`WRITE`=0, `SIZE`=00, `DAD`=0, `IAD`=`IMEM_START`, `DDT` high-Z.
  - All pulses 0, `d_rdata`=`f_inst`=0, ready=1.
  - Any in-flight access is abandoned silently.

## Timing
- All bus outputs are registered off posedge. The responder samples them at negedge and drives data and acknowledge before the next posedge.
- **Zero-wait-state access:** request accepted at E0 → `MREQ` high after E0 → acknowledge sampled at E1.
  - After E1: `d_done`=1 and `MREQ`=0.
  - The next request can be accepted at E2.
  - Throughput is one access per 2 cycles per channel.
- **N-cycle responder:** done at E(N).
- **Ready:** ready=0 from the accept edge to the completing edge. Requests presented while ready=0 are not accepted; the requester holds them.
- **Done/valid pulses:** exactly one cycle. Outputs hold until the next completion.

## Structure
- **Shared package `mem_bus_pkg`:**
  - Size constants `SZ_WORD`=2'b00, `SZ_HALF`=2'b01, `SZ_BYTE`=2'b10.
  - Channel state enum IDLE/BUSY.
  - Bus address constants `STDOUT_ADDR`=32'hf000_0000 and `EXIT_ADDR`=32'hff00_0000.
- **Sub-module `bus_chan_ctrl`:** IDLE/BUSY FSM, timeout counter of width $clog2(`TIMEOUT`+1), ack qualification, done/err pulse. Instantiated once for fetch and once for data.

## Test plan
- **Word load:** `d_req` at addr 0800_0010 with memory bytes 11 22 33 44, zero-wait responder → `MREQ` high one cycle, `SIZE`=00, `d_rdata`=1122_3344, `d_done` one cycle later.
- **Signed byte load:** responder returns DDT[7:0]=8'h80 → `d_rdata`=FFFF_FF80. Same access with `d_unsigned`=1 → `d_rdata`=0000_0080.
- **Half store:** `d_wdata`=DEAD_BEEF to 0800_0002 → `SIZE`=01, `WRITE`=1, DDT=0000_BEEF while `MREQ`. `DDT` is high-Z the following cycle.
- **Misaligned word:** word load at addr 0800_0001 → `MREQ` never rises, `d_done`=`d_err`=1.
- **Timeout:** responder holds `ACKI_n`/`ACKD_n` high and `TIMEOUT`=4 → strobe drops after 4 edges, err pulse. A stale low ACKD_n asserted while IDLE produces no `d_done`.
- **Reset mid-store:** assert `rst` low while `MREQ`=1 → `MREQ`/`WRITE` immediately 0, `DDT` high-Z, `IAD`=0, and no done pulse after release.
